// File: rtl/ccode_update.sv
// ---------------------------------------------------------------------------
// ccode_update
//   Producer side of the NVZ condition-code interface. Derives N, V and Z from
//   single-cycle ALU results or from the multi-cycle (MAC/accumulate) unit,
//   applies a per-opcode write mask and holds the flags in a register that the
//   condition evaluator reads as {N,V,Z}.
//
// Optional feature: define FLAG_FWD_EN to add the nvz_fwd output, a
//   combinational view of the value NVZ takes at the coming clock edge.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   ex_valid     in   instruction in EX is valid
//   ex_op        in   opcode of the EX instruction (selects the write mask)
//   alu_out      in   single-cycle ALU result
//   alu_ovfl     in   single-cycle ALU overflow
//   multi_cycle  in   EX op completes on the multi-cycle unit
//   mc_done      in   multi-cycle result valid this cycle (1-cycle pulse)
//   mc_result    in   multi-cycle result
//   mc_ovfl      in   multi-cycle overflow
//   stall        in   EX instruction is not accepted this cycle
//   flush        in   squash EX instruction / abort a pending multi-cycle update
//   NVZ          out  registered flags {N,V,Z}
//   flags_busy   out  flags await a multi-cycle result; consumers must stall
//   nvz_fwd      out  (FLAG_FWD_EN only) next value of NVZ
// ---------------------------------------------------------------------------
module ccode_update #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,
    input  logic              multi_cycle,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_result,
    input  logic              mc_ovfl,
    input  logic              stall,
    input  logic              flush,
    output logic [2:0]        NVZ,
    output logic              flags_busy
`ifdef FLAG_FWD_EN
    ,
    output logic [2:0]        nvz_fwd
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] nvz_q,   nvz_d;
    logic [2:0] mask_q,  mask_d;

    logic [2:0] ex_mask;
    logic       accept;

    // Write mask in {N,V,Z} order: arithmetic ops own all three flags,
    // logic/shift ops only own Z, everything else leaves the flags alone.
    function automatic logic [2:0] op_mask(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            4'b0000, 4'b0001, 4'b1000:          m = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: m = 3'b001;
            default:                            m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] derive(input logic [DATA_W-1:0] r,
                                          input logic              o);
        return {r[DATA_W-1], o, (r == {DATA_W{1'b0}})};
    endfunction

    // Merge freshly derived flags into the held flags under a mask.
    function automatic logic [2:0] merge(input logic [2:0] old_f,
                                         input logic [2:0] new_f,
                                         input logic [2:0] m);
        return (old_f & ~m) | (new_f & m);
    endfunction

    assign ex_mask = op_mask(ex_op);
    // Flush beats stall; opcodes with an empty mask never enter the machine,
    // so a no-flag multi-cycle op cannot make consumers wait for nothing.
    assign accept  = ex_valid & ~stall & ~flush & (ex_mask != 3'b000);

    // Next-state and next-flag logic. In WAIT the EX stage is stalled
    // upstream, so ex_valid is deliberately not looked at there.
    always_comb begin
        state_d = state_q;
        nvz_d   = nvz_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (multi_cycle) begin
                        mask_d  = ex_mask;
                        state_d = S_WAIT;
                    end else begin
                        nvz_d = merge(nvz_q, derive(alu_out, alu_ovfl), ex_mask);
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    mask_d  = 3'b000;
                    state_d = S_IDLE;
                end else if (mc_done) begin
                    nvz_d   = merge(nvz_q, derive(mc_result, mc_ovfl), mask_q);
                    mask_d  = 3'b000;
                    state_d = S_IDLE;
                end
            end
            default: begin
                mask_d  = 3'b000;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, flag and latched-mask registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nvz_q   <= 3'b000;
            mask_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            nvz_q   <= nvz_d;
            mask_q  <= mask_d;
        end
    end

    assign NVZ        = nvz_q;
    assign flags_busy = (state_q == S_WAIT);

`ifdef FLAG_FWD_EN
    // Mirror the register input, including the reset override, so the
    // evaluator sees exactly what NVZ will hold after the edge.
    assign nvz_fwd = rst_n ? nvz_d : 3'b000;
`endif

endmodule

// File: tb/tb_ccode_update.sv
// ---------------------------------------------------------------------------
// tb_ccode_update
//   Directed testbench for ccode_update. Inputs are changed 1 time unit after
//   the rising edge and outputs are checked there as well, so registered
//   values are stable and combinational forwarding can be seen pre-edge.
//   Define FLAG_FWD_EN to also exercise the nvz_fwd output.
// ---------------------------------------------------------------------------
module tb_ccode_update;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_MAC = 4'b1000;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic [3:0]        ex_op;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovfl;
    logic              multi_cycle;
    logic              mc_done;
    logic [DATA_W-1:0] mc_result;
    logic              mc_ovfl;
    logic              stall;
    logic              flush;
    logic [2:0]        NVZ;
    logic              flags_busy;
`ifdef FLAG_FWD_EN
    logic [2:0]        nvz_fwd;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ccode_update #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .alu_out     (alu_out),
        .alu_ovfl    (alu_ovfl),
        .multi_cycle (multi_cycle),
        .mc_done     (mc_done),
        .mc_result   (mc_result),
        .mc_ovfl     (mc_ovfl),
        .stall       (stall),
        .flush       (flush),
        .NVZ         (NVZ),
        .flags_busy  (flags_busy)
`ifdef FLAG_FWD_EN
        ,
        .nvz_fwd     (nvz_fwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold EX stalled while the flags are busy; the bench is
    // the upstream here, so this also guards against the DUT raising busy
    // when it should not.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(flags_busy && ex_valid && !stall && !flush))
            else begin
                miscompares++;
                $error("[TB] FAIL upstream_stall: observed busy=%b valid=%b stall=%b, required no unstalled issue while busy",
                       flags_busy, ex_valid, stall);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic              valid,
                                 input logic [3:0]        op,
                                 input logic [DATA_W-1:0] res,
                                 input logic              ovfl,
                                 input logic              mc,
                                 input logic              stl,
                                 input logic              fl);
        ex_valid    = valid;
        ex_op       = op;
        alu_out     = res;
        alu_ovfl    = ovfl;
        multi_cycle = mc;
        stall       = stl;
        flush       = fl;
    endtask

    task automatic applyMc(input logic              done,
                           input logic [DATA_W-1:0] res,
                           input logic              ovfl);
        mc_done   = done;
        mc_result = res;
        mc_ovfl   = ovfl;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyMc(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic checkOutput(input string      tag,
                               input logic [2:0] exp_nvz,
                               input logic       exp_busy);
        vectors++;
        assert ({NVZ, flags_busy} === {exp_nvz, exp_busy})
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed NVZ=%b busy=%b, expected NVZ=%b busy=%b",
                   tag, NVZ, flags_busy, exp_nvz, exp_busy);
        end
    endtask

`ifdef FLAG_FWD_EN
    task automatic checkFwd(input string tag, input logic [2:0] exp_fwd);
        vectors++;
        assert (nvz_fwd === exp_fwd)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed nvz_fwd=%b, expected %b", tag, nvz_fwd, exp_fwd);
        end
    endtask
`endif

    initial begin
        // Reset held for two cycles while the inputs wander randomly
        rst_n = 1'b0;
        idleInputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
            applyMc(1'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end
        checkOutput("reset", 3'b000, 1'b0);
        rst_n = 1'b1;
        idleInputs();
        tick();
        checkOutput("post_reset_idle", 3'b000, 1'b0);

        // ADD sets all flags, Z-only ops touch nothing but Z
        applyStimulus(1'b1, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("add_neg_ovfl", 3'b110, 1'b0);
        applyStimulus(1'b1, OP_XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("xor_zero", 3'b111, 1'b0);
        applyStimulus(1'b1, OP_SLL, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sll_nonzero", 3'b110, 1'b0);
        applyStimulus(1'b1, OP_ROR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ror_zero", 3'b111, 1'b0);
        applyStimulus(1'b1, OP_NOP, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("unmasked_op", 3'b111, 1'b0);
        applyStimulus(1'b0, OP_ADD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("invalid_add", 3'b111, 1'b0);

        // Stall holds off a SUB until released; flush never writes
        applyStimulus(1'b1, OP_SUB, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sub_stalled", 3'b111, 1'b0);
        applyStimulus(1'b1, OP_SUB, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sub_released", 3'b000, 1'b0);
        applyStimulus(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("add_flushed", 3'b000, 1'b0);
        applyStimulus(1'b1, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("stall_and_flush", 3'b000, 1'b0);
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("mac_flushed_no_wait", 3'b000, 1'b0);

        // MAC: busy from the next cycle, result 3 cycles after issue
        applyStimulus(1'b1, OP_MAC, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mac_issue_busy", 3'b000, 1'b1);
        applyStimulus(1'b1, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("mac_wait_1", 3'b000, 1'b1);
        tick();
        checkOutput("mac_wait_2", 3'b000, 1'b1);
        applyMc(1'b1, 16'h0000, 1'b0);
        tick();
        checkOutput("mac_done_zero", 3'b001, 1'b0);
        idleInputs();
        applyMc(1'b1, 16'h8000, 1'b1);
        tick();
        checkOutput("mc_done_in_idle", 3'b001, 1'b0);

        // Second MAC writing N and V
        idleInputs();
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyMc(1'b1, 16'hFFFF, 1'b1);
        tick();
        checkOutput("mac_done_neg_ovfl", 3'b110, 1'b0);

        // Flush aborts a pending MAC; a late mc_done is ignored
        idleInputs();
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mac2_busy", 3'b110, 1'b1);
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("mac2_flushed", 3'b110, 1'b0);
        idleInputs();
        applyMc(1'b1, 16'h0000, 1'b0);
        tick();
        checkOutput("late_mc_done", 3'b110, 1'b0);

        // Flush coincident with mc_done also discards the result
        idleInputs();
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyMc(1'b1, 16'h0000, 1'b0);
        tick();
        checkOutput("flush_with_done", 3'b110, 1'b0);

        // Reset in WAIT clears flags and drops the pending update
        idleInputs();
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mac3_busy", 3'b110, 1'b1);
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        checkOutput("reset_in_wait", 3'b000, 1'b0);
        rst_n = 1'b1;
        idleInputs();
        applyMc(1'b1, 16'h8000, 1'b1);
        tick();
        checkOutput("done_after_reset", 3'b000, 1'b0);

`ifdef FLAG_FWD_EN
        // Forwarded flags appear before the edge that registers them
        idleInputs();
        applyStimulus(1'b1, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkFwd("fwd_add_zero", 3'b001);
        tick();
        checkOutput("fwd_add_zero_reg", 3'b001, 1'b0);
        applyStimulus(1'b1, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checkFwd("fwd_stalled", 3'b001);
        applyStimulus(1'b1, OP_MAC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, OP_NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkFwd("fwd_wait_no_done", 3'b001);
        applyMc(1'b1, 16'h8000, 1'b1);
        #1;
        checkFwd("fwd_wait_done", 3'b110);
        tick();
        checkOutput("fwd_wait_done_reg", 3'b110, 1'b0);
`endif

        idleInputs();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
